lighting_cmd_seq: RTL and testbench
===================================

Name: lighting_cmd_seq

Overview:
Command sequencer that drives the LightingSystem inputs: generates the one-hot time-of-day code `tcode` from a clocked phase timer. It also accepts user lighting requests (`ulight`, `lenght`) over a valid/ready handshake. Requests are applied only at phase boundaries, so LightingSystem sees stable inputs within a phase. Sits between the user-input front end and LightingSystem.

Parameters:
TICKS_PER_PHASE, 16, clock cycles spent in each day phase (legal range 2..255)
CNT_W, 8, width of the phase tick counter (must hold TICKS_PER_PHASE-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low pauses the sequencer
req_valid  in  1  user request valid
req_ulight  in  4  requested user light code
req_lenght  in  4  requested length value
req_ready  out  1  sequencer can accept a request
req_err  out  1  one-cycle pulse: request rejected
tcode  out  4  one-hot phase code to LightingSystem
ulight  out  4  applied user light code to LightingSystem
lenght  out  4  applied length to LightingSystem
phase_strobe  out  1  one-cycle pulse on every tcode change
day_count  out  8  completed-day counter

Behaviour:
- Reset (async, rst_n=0) forces the following, regardless of clk. Pending request is discarded.
  - tcode=0000, ulight=0000, lenght=0000.
  - req_ready=1, req_err=0, phase_strobe=0, day_count=0.
  - State=IDLE, tick counter=0, pending flag=0.
- States and tcode values: IDLE 0000, MORNING 0001, NOON 0010, EVENING 0100, NIGHT 1000. tcode is registered and always one of these five values.
- IDLE: on the first edge with en=1, go to MORNING with counter=0 and phase_strobe=1 for that cycle.
- Active phase with en=1: counter increments each cycle. When counter==TICKS_PER_PHASE-1, the next edge is a boundary:
  - Advance MORNING->NOON->EVENING->NIGHT->MORNING.
  - Counter resets to 0 and phase_strobe pulses.
- NIGHT->MORNING boundary: day_count increments, wrapping 255->0.
- en=0 in an active phase: tcode and counter freeze, no strobe; resume continues from the frozen count. en=0 in IDLE: remain in IDLE.
- Handshake: a transfer occurs on an edge where req_valid=1 and req_ready=1.
  - Accepted request: stored as pending, pending flag set, req_ready=0 from the next cycle.
  - req_lenght==0: not stored; req_err=1 for exactly one cycle; req_ready stays 1.
- Applying a pending request (pending flag already set before the edge):
  - At a boundary edge, or at any edge while in IDLE: ulight/lenght load from pending, pending flag clears, req_ready=1 from the next cycle.
  - If the boundary is paused (en=0), application waits with it.
- Simultaneous events: a request accepted on a boundary edge becomes pending and applies at the following boundary, never on the same edge.
- req_valid while req_ready=0 is ignored. The requester holds it; no error is raised.
- Outputs ulight/lenght change only on boundary edges or in IDLE.

Optional Feature:
Macro LSEQ_FORCE_PHASE_EN.
- Defined: adds inputs force_valid (1) and force_tcode (4).
  - force_valid=1 with force_tcode one-hot: next edge jumps to that phase, counter=0, phase_strobe=1. Pending is applied as at a boundary; day_count is unchanged.
  - Non-one-hot force_tcode: ignored, req_err pulses.
  - force_valid overrides en and any natural boundary on the same edge.
- Undefined: ports are absent and the phase is driven by the timer only.

Test Plan:
1. TICKS_PER_PHASE=4; reset then en=1 -> tcode 0000, then 0001 on the next edge; 0010/0100/1000 every 4 cycles; 0001 again with day_count=1; phase_strobe high exactly on each change.
2. Mid-MORNING, req_ulight=1010, req_lenght=1100 -> req_ready=0 the next cycle; ulight=1010 and lenght=1100 on the same edge tcode becomes 0010; req_ready=1 one cycle later.
3. Mid-NOON at counter=2, en=0 for 10 cycles -> tcode holds 0010, no strobe; after en=1, NOON lasts 2 more cycles.
4. req_lenght=0000 with req_valid=1 -> req_err single pulse, req_ready stays 1, ulight/lenght unchanged; next valid request accepted normally.
5. rst_n=0 mid-EVENING with a request pending -> tcode/ulight/lenght=0000 and day_count=0 immediately (before the next clk edge); after release, sequencer restarts from IDLE.
6. With LSEQ_FORCE_PHASE_EN, force_tcode=1000 during NOON -> tcode=1000 next edge, counter restarts, day_count unchanged; force_tcode=0110 -> ignored, req_err pulse.

Source files
------------

// File: rtl/lighting_cmd_seq.sv
// Phase sequencer for LightingSystem: one-hot time-of-day code plus user requests applied at phase boundaries.
// Optional macro LSEQ_FORCE_PHASE_EN adds force_valid/force_tcode for direct phase jumps.
module lighting_cmd_seq #(
  parameter int unsigned TICKS_PER_PHASE = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       req_valid,
  input  logic [3:0] req_ulight,
  input  logic [3:0] req_lenght,
`ifdef LSEQ_FORCE_PHASE_EN
  input  logic       force_valid,
  input  logic [3:0] force_tcode,
`endif
  output logic       req_ready,
  output logic       req_err,
  output logic [3:0] tcode,
  output logic [3:0] ulight,
  output logic [3:0] lenght,
  output logic       phase_strobe,
  output logic [7:0] day_count
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned DAY_W  = 8;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_PHASE - 1);

  typedef enum logic [CODE_W-1:0] {
    IDLE    = 4'b0000,
    MORNING = 4'b0001,
    NOON    = 4'b0010,
    EVENING = 4'b0100,
    NIGHT   = 4'b1000
  } state_t;

  state_t              r_state, w_state_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [DAY_W-1:0]    r_day, w_day_n;
  logic                r_pend, w_pend_n;
  logic [CODE_W-1:0]   r_pend_ulight, w_pend_ulight_n;
  logic [CODE_W-1:0]   r_pend_lenght, w_pend_lenght_n;
  logic [CODE_W-1:0]   r_ulight, w_ulight_n;
  logic [CODE_W-1:0]   r_lenght, w_lenght_n;
  logic                r_ready, r_err, w_err_n, r_strobe, w_strobe_n;
  logic                w_boundary, w_force_ok, w_apply, w_accept;

  // Next-state, timer, day counter and request handling
  always_comb begin
    w_state_n       = r_state;
    w_cnt_n         = r_cnt;
    w_day_n         = r_day;
    w_pend_n        = r_pend;
    w_pend_ulight_n = r_pend_ulight;
    w_pend_lenght_n = r_pend_lenght;
    w_ulight_n      = r_ulight;
    w_lenght_n      = r_lenght;
    w_err_n         = 1'b0;
    w_strobe_n      = 1'b0;
    w_force_ok      = 1'b0;
    w_boundary      = (r_state != IDLE) && en && (r_cnt == LAST_TICK);

    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_n  = MORNING;
          w_cnt_n    = '0;
          w_strobe_n = 1'b1;
        end
      end
      default: begin
        if (w_boundary) begin
          w_cnt_n    = '0;
          w_strobe_n = 1'b1;
          case (r_state)
            MORNING: w_state_n = NOON;
            NOON:    w_state_n = EVENING;
            EVENING: w_state_n = NIGHT;
            default: begin
              w_state_n = MORNING;
              w_day_n   = r_day + DAY_W'(1);
            end
          endcase
        end else if (en) begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
    endcase

`ifdef LSEQ_FORCE_PHASE_EN
    // A legal force beats both en and a natural boundary; an illegal one only flags an error
    if (force_valid) begin
      if ($onehot(force_tcode)) begin
        w_force_ok = 1'b1;
        w_state_n  = state_t'(force_tcode);
        w_cnt_n    = '0;
        w_strobe_n = 1'b1;
        w_day_n    = r_day;
      end else begin
        w_err_n = 1'b1;
      end
    end
`endif

    // Pending data applies only when inputs to LightingSystem may change
    w_apply = r_pend && (w_boundary || (r_state == IDLE) || w_force_ok);
    if (w_apply) begin
      w_ulight_n = r_pend_ulight;
      w_lenght_n = r_pend_lenght;
      w_pend_n   = 1'b0;
    end

    w_accept = req_valid && r_ready;
    if (w_accept) begin
      if (req_lenght == '0) begin
        w_err_n = 1'b1;
      end else begin
        w_pend_n        = 1'b1;
        w_pend_ulight_n = req_ulight;
        w_pend_lenght_n = req_lenght;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_day         <= '0;
      r_pend        <= 1'b0;
      r_pend_ulight <= '0;
      r_pend_lenght <= '0;
      r_ulight      <= '0;
      r_lenght      <= '0;
      r_ready       <= 1'b1;
      r_err         <= 1'b0;
      r_strobe      <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_cnt         <= w_cnt_n;
      r_day         <= w_day_n;
      r_pend        <= w_pend_n;
      r_pend_ulight <= w_pend_ulight_n;
      r_pend_lenght <= w_pend_lenght_n;
      r_ulight      <= w_ulight_n;
      r_lenght      <= w_lenght_n;
      r_ready       <= ~w_pend_n;
      r_err         <= w_err_n;
      r_strobe      <= w_strobe_n;
    end
  end

  assign tcode        = r_state;
  assign ulight       = r_ulight;
  assign lenght       = r_lenght;
  assign req_ready    = r_ready;
  assign req_err      = r_err;
  assign phase_strobe = r_strobe;
  assign day_count    = r_day;

endmodule

// File: tb/tb_lighting_cmd_seq.sv
// Directed self-checking bench for lighting_cmd_seq with TICKS_PER_PHASE=4.
module tb_lighting_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       req_valid;
  logic [3:0] req_ulight;
  logic [3:0] req_lenght;
  logic       req_ready;
  logic       req_err;
  logic [3:0] tcode;
  logic [3:0] ulight;
  logic [3:0] lenght;
  logic       phase_strobe;
  logic [7:0] day_count;
`ifdef LSEQ_FORCE_PHASE_EN
  logic       force_valid;
  logic [3:0] force_tcode;
`endif

  int total = 0;
  int bad   = 0;

  lighting_cmd_seq #(.TICKS_PER_PHASE(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .req_valid    (req_valid),
    .req_ulight   (req_ulight),
    .req_lenght   (req_lenght),
`ifdef LSEQ_FORCE_PHASE_EN
    .force_valid  (force_valid),
    .force_tcode  (force_tcode),
`endif
    .req_ready    (req_ready),
    .req_err      (req_err),
    .tcode        (tcode),
    .ulight       (ulight),
    .lenght       (lenght),
    .phase_strobe (phase_strobe),
    .day_count    (day_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] phase_seq [4];

  initial begin
    phase_seq[0] = 4'b0010;
    phase_seq[1] = 4'b0100;
    phase_seq[2] = 4'b1000;
    phase_seq[3] = 4'b0001;
    rst_n = 1'b0; en = 1'b0; req_valid = 1'b0; req_ulight = '0; req_lenght = '0;
`ifdef LSEQ_FORCE_PHASE_EN
    force_valid = 1'b0; force_tcode = '0;
`endif
    step(); step();
    rst_n = 1'b1;

    // reset state
    chk("rst_tcode", 32'(tcode), 32'h0);
    chk("rst_ulight", 32'(ulight), 32'h0);
    chk("rst_lenght", 32'(lenght), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_err", 32'(req_err), 32'h0);
    chk("rst_strobe", 32'(phase_strobe), 32'h0);
    chk("rst_day", 32'(day_count), 32'h0);

    // test 1: full day of phases
    en = 1'b1;
    step();
    chk("t1_morning", 32'(tcode), 32'h1);
    chk("t1_morning_strobe", 32'(phase_strobe), 32'h1);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 3; k++) begin
        step();
        chk("t1_hold_strobe", 32'(phase_strobe), 32'h0);
      end
      step();
      chk("t1_phase", 32'(tcode), 32'(phase_seq[p]));
      chk("t1_strobe", 32'(phase_strobe), 32'h1);
    end
    chk("t1_day", 32'(day_count), 32'h1);

    // test 2: request mid-MORNING (cnt=0 now); second valid while busy ignored
    step();
    req_valid = 1'b1; req_ulight = 4'b1010; req_lenght = 4'b1100;
    step();
    chk("t2_ready_low", 32'(req_ready), 32'h0);
    chk("t2_ulight_hold", 32'(ulight), 32'h0);
    req_ulight = 4'b1111; req_lenght = 4'b1111;
    step();
    chk("t2_busy_noerr", 32'(req_err), 32'h0);
    chk("t2_still_morning", 32'(tcode), 32'h1);
    req_valid = 1'b0;
    step();
    chk("t2_noon", 32'(tcode), 32'h2);
    chk("t2_ulight", 32'(ulight), 32'hA);
    chk("t2_lenght", 32'(lenght), 32'hC);
    chk("t2_ready_high", 32'(req_ready), 32'h1);

    // test 3: pause at NOON count 2
    step(); step();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t3_pause_tcode", 32'(tcode), 32'h2);
      chk("t3_pause_strobe", 32'(phase_strobe), 32'h0);
    end
    en = 1'b1;
    step();
    chk("t3_resume_noon", 32'(tcode), 32'h2);
    step();
    chk("t3_evening", 32'(tcode), 32'h4);
    chk("t3_evening_strobe", 32'(phase_strobe), 32'h1);

    // test 4: zero length rejected, then a good request accepted
    req_valid = 1'b1; req_ulight = 4'b0101; req_lenght = 4'b0000;
    step();
    chk("t4_err", 32'(req_err), 32'h1);
    chk("t4_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b0;
    step();
    chk("t4_err_clear", 32'(req_err), 32'h0);
    chk("t4_ulight_keep", 32'(ulight), 32'hA);
    chk("t4_lenght_keep", 32'(lenght), 32'hC);
    req_valid = 1'b1; req_ulight = 4'b0011; req_lenght = 4'b0111;
    step();
    chk("t4_accept", 32'(req_ready), 32'h0);
    chk("t4_accept_noerr", 32'(req_err), 32'h0);
    req_valid = 1'b0;

    // test 5: async reset mid-EVENING with a pending request
    #2 rst_n = 1'b0;
    #1;
    chk("t5_tcode", 32'(tcode), 32'h0);
    chk("t5_ulight", 32'(ulight), 32'h0);
    chk("t5_lenght", 32'(lenght), 32'h0);
    chk("t5_day", 32'(day_count), 32'h0);
    chk("t5_ready", 32'(req_ready), 32'h1);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_restart", 32'(tcode), 32'h1);
    chk("t5_restart_strobe", 32'(phase_strobe), 32'h1);
    chk("t5_discarded", 32'(ulight), 32'h0);

`ifdef LSEQ_FORCE_PHASE_EN
    // test 6: forced phase jump and illegal force code
    for (int k = 0; k < 4; k++) step();
    chk("t6_noon", 32'(tcode), 32'h2);
    force_valid = 1'b1; force_tcode = 4'b1000;
    step();
    chk("t6_forced", 32'(tcode), 32'h8);
    chk("t6_forced_strobe", 32'(phase_strobe), 32'h1);
    chk("t6_day", 32'(day_count), 32'h0);
    force_tcode = 4'b0110;
    step();
    force_valid = 1'b0;
    chk("t6_bad_err", 32'(req_err), 32'h1);
    chk("t6_bad_tcode", 32'(tcode), 32'h8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
